// File: rtl/clock_time_bcd_if.sv
// Button inputs and display/status outputs of the clock time-keeping core.
// The master side drives the buttons and the slave side (the core) drives the display.
interface clock_time_bcd_if;
  logic       mode_i;
  logic       inc_i;
  logic [3:0] hour_ten;
  logic [3:0] hour_one;
  logic [3:0] min_ten;
  logic [3:0] min_one;
  logic [3:0] sec_ten;
  logic [3:0] sec_one;
  logic [1:0] mode_o;
  logic       sec_tick_o;

  modport master (
    output mode_i, inc_i,
    input  hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one, mode_o, sec_tick_o
  );

  modport slave (
    input  mode_i, inc_i,
    output hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one, mode_o, sec_tick_o
  );
endinterface

// File: rtl/clock_time_bcd.sv
// 24-hour HH:MM:SS BCD time keeper with a 1 Hz prescaler and a run / set-hour / set-minute mode.
// Buttons arrive debounced and synchronised; actions fire on their rising edges.
module clock_time_bcd #(
  parameter int CLK_DIV = 50000000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  clock_time_bcd_if.slave bus
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_HOUR = 2'b01;
  localparam logic [1:0] ST_SET_MIN  = 2'b10;

  logic          r_mode_prev;
  logic          r_inc_prev;
  logic [1:0]    r_mode;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic [3:0]    r_hour_ten;
  logic [3:0]    r_hour_one;
  logic [3:0]    r_min_ten;
  logic [3:0]    r_min_one;
  logic [3:0]    r_sec_ten;
  logic [3:0]    r_sec_one;

  logic       w_mode_edge;
  logic       w_inc_edge;
  logic       w_presc_term;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic [3:0] w_min_one_inc;
  logic [3:0] w_min_ten_inc;
  logic [3:0] w_hour_one_inc;
  logic [3:0] w_hour_ten_inc;

  assign w_mode_edge  = bus.mode_i & ~r_mode_prev;
  assign w_inc_edge   = bus.inc_i & ~r_inc_prev;
  assign w_presc_term = (r_presc == PRESC_MAX);
  assign w_sec_wrap   = (r_sec_one == 4'd9) && (r_sec_ten == 4'd5);
  assign w_min_wrap   = (r_min_one == 4'd9) && (r_min_ten == 4'd5);

  // Next minute value, shared by the seconds carry and the set-minute button (no hour carry).
  assign w_min_one_inc = (r_min_one == 4'd9) ? 4'd0 : r_min_one + 4'd1;
  assign w_min_ten_inc = (r_min_one != 4'd9) ? r_min_ten :
                         (r_min_ten == 4'd5) ? 4'd0 : r_min_ten + 4'd1;

  always_comb begin
    w_hour_one_inc = r_hour_one + 4'd1;
    w_hour_ten_inc = r_hour_ten;
    if (r_hour_ten == 4'd2 && r_hour_one == 4'd3) begin
      w_hour_one_inc = 4'd0;
      w_hour_ten_inc = 4'd0;
    end else if (r_hour_one == 4'd9) begin
      w_hour_one_inc = 4'd0;
      w_hour_ten_inc = r_hour_ten + 4'd1;
    end
  end

  // Sampled through reset too, so a button held across reset gives no edge afterwards.
  always_ff @(posedge clk_i) begin
    r_mode_prev <= bus.mode_i;
    r_inc_prev  <= bus.inc_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mode     <= ST_RUN;
      r_presc    <= '0;
      r_tick     <= 1'b0;
      r_hour_ten <= 4'd0;
      r_hour_one <= 4'd0;
      r_min_ten  <= 4'd0;
      r_min_one  <= 4'd0;
      r_sec_ten  <= 4'd0;
      r_sec_one  <= 4'd0;
    end else begin
      r_tick <= 1'b0;
      if (w_mode_edge) begin
        // A mode step pre-empts both a pending advance and a simultaneous inc.
        r_presc <= '0;
        case (r_mode)
          ST_RUN:      r_mode <= ST_SET_HOUR;
          ST_SET_HOUR: r_mode <= ST_SET_MIN;
          default: begin
            r_mode    <= ST_RUN;
            r_sec_ten <= 4'd0;
            r_sec_one <= 4'd0;
          end
        endcase
      end else begin
        case (r_mode)
          ST_RUN: begin
            if (w_presc_term) begin
              r_presc   <= '0;
              r_tick    <= 1'b1;
              r_sec_one <= (r_sec_one == 4'd9) ? 4'd0 : r_sec_one + 4'd1;
              if (r_sec_one == 4'd9)
                r_sec_ten <= (r_sec_ten == 4'd5) ? 4'd0 : r_sec_ten + 4'd1;
              if (w_sec_wrap) begin
                r_min_one <= w_min_one_inc;
                r_min_ten <= w_min_ten_inc;
                if (w_min_wrap) begin
                  r_hour_one <= w_hour_one_inc;
                  r_hour_ten <= w_hour_ten_inc;
                end
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          ST_SET_HOUR: begin
            r_presc <= '0;
            if (w_inc_edge) begin
              r_hour_one <= w_hour_one_inc;
              r_hour_ten <= w_hour_ten_inc;
            end
          end
          default: begin
            r_presc <= '0;
            if (w_inc_edge) begin
              r_min_one <= w_min_one_inc;
              r_min_ten <= w_min_ten_inc;
            end
          end
        endcase
      end
    end
  end

  assign bus.hour_ten   = r_hour_ten;
  assign bus.hour_one   = r_hour_one;
  assign bus.min_ten    = r_min_ten;
  assign bus.min_one    = r_min_one;
  assign bus.sec_ten    = r_sec_ten;
  assign bus.sec_one    = r_sec_one;
  assign bus.mode_o     = r_mode;
  assign bus.sec_tick_o = r_tick;

endmodule

// File: tb/tb_clock_time_bcd.sv
// Bench for clock_time_bcd with CLK_DIV = 4: directed scenarios plus random button traffic,
// every cycle compared against a seconds-of-day reference model.
module tb_clock_time_bcd;

  localparam int CLK_DIV = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  clock_time_bcd_if bus();

  clock_time_bcd #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time as seconds since midnight, mode as 0/1/2.
  int m_t    = 0;
  int m_mode = 0;
  int m_pc   = 0;
  bit m_tick = 1'b0;
  bit m_pm   = 1'b0;
  bit m_pi   = 1'b0;

  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input bit rst, input bit md, input bit ic);
    bit me, ie;
    int hh, mm;
    me = md && !m_pm;
    ie = ic && !m_pi;
    m_tick = 1'b0;
    if (rst) begin
      m_t = 0; m_mode = 0; m_pc = 0;
    end else if (me) begin
      if (m_mode == 2) m_t = m_t - (m_t % 60);
      m_mode = (m_mode + 1) % 3;
      m_pc = 0;
    end else if (m_mode == 0) begin
      if (m_pc == CLK_DIV - 1) begin
        m_pc = 0;
        m_t = (m_t + 1) % 86400;
        m_tick = 1'b1;
      end else begin
        m_pc++;
      end
    end else if (m_mode == 1) begin
      if (ie) begin
        hh = (m_t / 3600 + 1) % 24;
        m_t = hh * 3600 + m_t % 3600;
      end
    end else if (ie) begin
      mm = ((m_t / 60) % 60 + 1) % 60;
      m_t = (m_t / 3600) * 3600 + mm * 60 + m_t % 60;
    end
    m_pm = md;
    m_pi = ic;
  endtask

  function automatic logic [23:0] bcd_hms(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] dut_digits();
    return {bus.hour_ten, bus.hour_one, bus.min_ten, bus.min_one, bus.sec_ten, bus.sec_one};
  endfunction

  function automatic logic [26:0] model_pack();
    return {2'(m_mode), bcd_hms(m_t / 3600, (m_t / 60) % 60, m_t % 60), m_tick};
  endfunction

  function automatic logic [26:0] dut_pack();
    return {bus.mode_o, dut_digits(), bus.sec_tick_o};
  endfunction

  task automatic clk_cycle(input bit rst, input bit md, input bit ic);
    rst_i = rst;
    bus.mode_i = md;
    bus.inc_i = ic;
    @(posedge clk_i);
    cyc++;
    model_step(rst, md, ic);
    #1;
    check_val("cycle", 32'(dut_pack()), 32'(model_pack()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_mode();
    clk_cycle(1'b0, 1'b1, 1'b0);
    clk_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      clk_cycle(1'b0, 1'b0, 1'b1);
      clk_cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int ticks, first_tick, last_tick;
    bus.mode_i = 1'b0;
    bus.inc_i  = 1'b0;

    // 1: reset then free-run one minute
    for (int i = 0; i < 3; i++) clk_cycle(1'b1, 1'b0, 1'b0);
    check_val("rst_digits", 32'(dut_digits()), 32'(bcd_hms(0, 0, 0)));
    check_val("rst_mode", 32'(bus.mode_o), 32'd0);
    check_val("rst_tick", 32'(bus.sec_tick_o), 32'd0);
    cyc = 0;
    ticks = 0; first_tick = -1; last_tick = 0;
    for (int i = 1; i <= 240; i++) begin
      clk_cycle(1'b0, 1'b0, 1'b0);
      if (bus.sec_tick_o) begin
        if (first_tick < 0) begin
          first_tick = i;
          check_val("first_tick_cycle", 32'(i), 32'(CLK_DIV));
        end else begin
          check_val("tick_gap", 32'(i - last_tick), 32'(CLK_DIV));
        end
        last_tick = i;
        ticks++;
      end
    end
    check_val("tick_count_60", 32'(ticks), 32'd60);
    check_val("one_minute", 32'(dut_digits()), 32'(bcd_hms(0, 1, 0)));
    $display("scenario 1: free run 240 cycles, %0d ticks", ticks);

    // 2: set 23:59, return to run, roll over midnight
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(58);
    press_mode();
    check_val("set_2359_mode", 32'(bus.mode_o), 32'd0);
    check_val("set_2359_time", 32'(dut_digits()), 32'(bcd_hms(23, 59, 0)));
    run(219);
    check_val("at_235955", 32'(dut_digits()), 32'(bcd_hms(23, 59, 55)));
    run(20);
    check_val("midnight", 32'(dut_digits()), 32'(bcd_hms(0, 0, 0)));
    run(12);
    check_val("midnight_plus3", 32'(dut_digits()), 32'(bcd_hms(0, 0, 3)));
    $display("scenario 2: 23:59:55 rolled to 00:00:00");

    // 3: set-hour wraps through 23 -> 00, seconds frozen, no ticks
    press_mode();
    check_val("set_hour_mode", 32'(bus.mode_o), 32'd1);
    press_inc(25);
    check_val("hours_after_25", 32'(dut_digits()), 32'(bcd_hms(1, 0, 3)));
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      clk_cycle(1'b0, 1'b0, 1'b0);
      if (bus.sec_tick_o) ticks++;
    end
    check_val("no_tick_in_set", 32'(ticks), 32'd0);
    check_val("frozen_time", 32'(dut_digits()), 32'(bcd_hms(1, 0, 3)));
    $display("scenario 3: set-hour wrap, time frozen");

    // 4: minute 59 -> 00 without hour carry; leaving set clears seconds
    press_mode();
    press_inc(59);
    check_val("min_59", 32'(dut_digits()), 32'(bcd_hms(1, 59, 3)));
    press_inc(1);
    check_val("min_wrap_no_carry", 32'(dut_digits()), 32'(bcd_hms(1, 0, 3)));
    press_mode();
    check_val("back_to_run", 32'(bus.mode_o), 32'd0);
    check_val("secs_cleared", 32'(dut_digits()), 32'(bcd_hms(1, 0, 0)));
    $display("scenario 4: minute wrap, seconds cleared on exit");

    // 5: simultaneous mode+inc, then inc held high
    press_mode();
    clk_cycle(1'b0, 1'b1, 1'b1);
    clk_cycle(1'b0, 1'b0, 1'b0);
    check_val("simul_mode", 32'(bus.mode_o), 32'd2);
    check_val("simul_hours", 32'(dut_digits()), 32'(bcd_hms(1, 0, 0)));
    for (int i = 0; i < 50; i++) clk_cycle(1'b0, 1'b0, 1'b1);
    clk_cycle(1'b0, 1'b0, 1'b0);
    check_val("held_inc_once", 32'(dut_digits()), 32'(bcd_hms(1, 1, 0)));
    press_mode();
    $display("scenario 5: mode wins, held inc counted once");

    // 6: reach 12:34:56, reset mid-count with inc held
    press_mode();
    press_inc(11);
    press_mode();
    press_inc(33);
    press_mode();
    run(223);
    check_val("at_123456", 32'(dut_digits()), 32'(bcd_hms(12, 34, 56)));
    run(2);
    clk_cycle(1'b1, 1'b0, 1'b1);
    clk_cycle(1'b1, 1'b0, 1'b1);
    clk_cycle(1'b0, 1'b0, 1'b1);
    clk_cycle(1'b0, 1'b1, 1'b1);
    clk_cycle(1'b0, 1'b0, 1'b1);
    check_val("rst_mid_time", 32'(dut_digits()), 32'(bcd_hms(0, 0, 0)));
    check_val("held_inc_no_edge_mode", 32'(bus.mode_o), 32'd1);
    clk_cycle(1'b0, 1'b0, 1'b0);
    check_val("held_inc_no_edge_hour", 32'(dut_digits()), 32'(bcd_hms(0, 0, 0)));
    clk_cycle(1'b1, 1'b0, 1'b0);
    check_val("rst_mode_run", 32'(bus.mode_o), 32'd0);
    $display("scenario 6: reset mid-count, held button ignored");

    // 7: random button traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      clk_cycle(($urandom % 400) == 0, ($urandom % 12) == 0, ($urandom % 3) == 0);
    end
    $display("scenario 7: 3000 random cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
